// File: rtl/openhw_gshare_ncnt.sv
// -----------------------------------------------------------------------------
// openhw_gshare_ncnt
//   Gshare branch-direction predictor with N-bit saturating counters, a global
//   history of arbitrary length XOR-folded into the PHT index, and a hardware
//   PHT initialisation sweep after reset. History is committed in M and rebuilt
//   speculatively for E/D/F. In-flight updates are forwarded to F so the PHT
//   needs no read/write bypass.
//
// Optional feature: define GSHARE_STATS_EN to add the saturating 32-bit
//   statistics outputs BranchCountE / MispredCountE.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   StallF..StallW, FlushD..FlushW   pipeline stall / flush controls
//   PCNextF, PCF, PCD, PCE, PCM      per-stage PCs (XLEN bits)
//   BPBranchF                        BTB says F holds a branch
//   BranchD..BranchW                 conditional branch present in stage
//   PCSrcE                           resolved direction in E (1 = taken)
//   BPDirPredF                       predicted counter, MSB = taken
//   BPDirPredWrongE                  direction mispredict in E
//   InitBusy                         PHT initialisation sweep in progress
//   BranchCountE, MispredCountE      statistics (GSHARE_STATS_EN only)
// -----------------------------------------------------------------------------
module openhw_gshare_ncnt #(
  parameter int XLEN  = 64,
  parameter int IDXW  = 10,
  parameter int HISTW = 10,
  parameter int CTRW  = 2,
  parameter int TYPE  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            StallE,
  input  logic            StallM,
  input  logic            StallW,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic            FlushM,
  input  logic            FlushW,
  input  logic [XLEN-1:0] PCNextF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCM,
  input  logic            BPBranchF,
  input  logic            BranchD,
  input  logic            BranchE,
  input  logic            BranchM,
  input  logic            BranchW,
  input  logic            PCSrcE,
  output logic [CTRW-1:0] BPDirPredF,
  output logic            BPDirPredWrongE,
`ifdef GSHARE_STATS_EN
  output logic [31:0]     BranchCountE,
  output logic [31:0]     MispredCountE,
`endif
  output logic            InitBusy
);

  localparam int DEPTH = 2 ** IDXW;
  localparam logic [CTRW-1:0] CTR_INIT = CTRW'((1 << (CTRW - 1)) - 1);
  localparam logic [CTRW-1:0] CTR_MAX  = '1;

  // Fold: bit i of the history lands in index bit (i mod IDXW), which is the
  // XOR of consecutive IDXW-bit slices with the last slice zero-extended.
  function automatic logic [IDXW-1:0] fold_hist(input logic [HISTW-1:0] h);
    logic [IDXW-1:0] f;
    f = '0;
    for (int i = 0; i < HISTW; i++) f[i % IDXW] = f[i % IDXW] ^ h[i];
    return f;
  endfunction

  function automatic logic [IDXW-1:0] pc_hash(input logic [XLEN-1:0] pc);
    logic [IDXW-1:0] r;
    r = pc[IDXW+1:2];
    r[IDXW-1] = r[IDXW-1] ^ pc[1];
    return r;
  endfunction

  function automatic logic [IDXW-1:0] make_index(input logic [HISTW-1:0] h,
                                                 input logic [XLEN-1:0] pc);
    if (TYPE == 1) return fold_hist(h) ^ pc_hash(pc);
    else           return fold_hist(h);
  endfunction

  // Newest outcome enters at the MSB; written without slices so HISTW=1 works.
  function automatic logic [HISTW-1:0] shift_in(input logic [HISTW-1:0] h, input logic b);
    return (h >> 1) | (HISTW'(b) << (HISTW - 1));
  endfunction

  function automatic logic [CTRW-1:0] sat_upd(input logic [CTRW-1:0] c, input logic t);
    if (t) return (c == CTR_MAX) ? c : c + CTRW'(1);
    else   return (c == '0)      ? c : c - CTRW'(1);
  endfunction

  // ---------------- init sweep FSM ----------------
  typedef enum logic {S_INIT, S_RUN} state_e;
  state_e          state_q, state_d;
  logic [IDXW-1:0] init_idx_q, init_idx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    InitBusy   = 1'b0;
    case (state_q)
      S_INIT: begin
        InitBusy   = 1'b1;
        init_idx_d = init_idx_q + IDXW'(1);
        if (init_idx_q == IDXW'(DEPTH - 1)) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  // ---------------- pipeline registers ----------------
  logic [CTRW-1:0] pred_d_q, pred_e_q, new_pred_m_q, new_pred_w_q, new_pred_e;
  logic            pcsrc_m_q;
  logic [IDXW-1:0] index_w_q;
  logic [IDXW-1:0] index_next_f, index_f, index_d, index_e, index_m;

  assign new_pred_e = sat_upd(pred_e_q, PCSrcE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_d_q     <= CTR_INIT;
      pred_e_q     <= CTR_INIT;
      new_pred_m_q <= CTR_INIT;
      new_pred_w_q <= CTR_INIT;
      pcsrc_m_q    <= 1'b0;
      index_w_q    <= '0;
    end else begin
      if (!StallD) pred_d_q <= FlushD ? CTR_INIT : BPDirPredF;
      if (!StallE) pred_e_q <= FlushE ? CTR_INIT : pred_d_q;
      if (!StallM) begin
        new_pred_m_q <= FlushM ? CTR_INIT : new_pred_e;
        pcsrc_m_q    <= FlushM ? 1'b0 : PCSrcE;
      end
      if (!StallW) begin
        new_pred_w_q <= FlushW ? CTR_INIT : new_pred_m_q;
        index_w_q    <= index_m;
      end
    end
  end

  // ---------------- global history ----------------
  logic [HISTW-1:0] ghr_m_q, ghr_e, ghr_d, ghr_f, ghr_next_f;
  logic             upd_m;

  assign upd_m = BranchM & ~StallW & ~FlushW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   ghr_m_q <= '0;
    else if (upd_m && !InitBusy) ghr_m_q <= shift_in(ghr_m_q, pcsrc_m_q);
  end

  // Younger stages see the committed history plus every older in-flight branch.
  assign ghr_e      = BranchM   ? shift_in(ghr_m_q, pcsrc_m_q)           : ghr_m_q;
  assign ghr_d      = BranchE   ? shift_in(ghr_e, PCSrcE)                : ghr_e;
  assign ghr_f      = BranchD   ? shift_in(ghr_d, pred_d_q[CTRW-1])      : ghr_d;
  assign ghr_next_f = BPBranchF ? shift_in(ghr_f, BPDirPredF[CTRW-1])    : ghr_f;

  assign index_next_f = make_index(ghr_next_f, PCNextF);
  assign index_f      = make_index(ghr_f, PCF);
  assign index_d      = make_index(ghr_d, PCD);
  assign index_e      = make_index(ghr_e, PCE);
  assign index_m      = make_index(ghr_m_q, PCM);

  // ---------------- PHT (1R1W, registered read) ----------------
  logic [CTRW-1:0] pht_mem [DEPTH];
  logic [CTRW-1:0] pht_rd_q, pht_wdata;
  logic [IDXW-1:0] pht_waddr;
  logic            pht_we;

  always_comb begin
    pht_we    = upd_m;
    pht_waddr = index_m;
    pht_wdata = new_pred_m_q;
    if (InitBusy) begin
      pht_we    = 1'b1;
      pht_waddr = init_idx_q;
      pht_wdata = CTR_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (pht_we)  pht_mem[pht_waddr] <= pht_wdata;
    if (!StallF) pht_rd_q <= pht_mem[index_next_f];
  end

  // ---------------- forwarding ----------------
  logic match_d, match_e, match_m, match_w;

  assign match_d = BranchD & ~FlushE & (index_f == index_d);
  assign match_e = BranchE & ~FlushM & (index_f == index_e);
  assign match_m = BranchM & ~FlushW & (index_f == index_m);
  assign match_w = BranchW & (index_f == index_w_q);

  always_comb begin
    BPDirPredF = pht_rd_q;
    if (InitBusy)     BPDirPredF = CTR_INIT;
    else if (match_d) BPDirPredF = {CTRW{pred_d_q[CTRW-1]}};
    else if (match_e) BPDirPredF = new_pred_e;
    else if (match_m) BPDirPredF = new_pred_m_q;
    else if (match_w) BPDirPredF = new_pred_w_q;
  end

  assign BPDirPredWrongE = BranchE & (PCSrcE != pred_e_q[CTRW-1]);

`ifdef GSHARE_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q;
  logic        stat_inc;

  assign stat_inc = BranchE & ~StallE & ~FlushM & ~InitBusy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (stat_inc && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (stat_inc && BPDirPredWrongE && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign BranchCountE  = br_cnt_q;
  assign MispredCountE = mis_cnt_q;
`endif

  // PC bits outside the hash window do not affect the index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCNextF[XLEN-1:IDXW+2], PCNextF[0], PCF[XLEN-1:IDXW+2], PCF[0],
                            PCD[XLEN-1:IDXW+2], PCD[0], PCE[XLEN-1:IDXW+2], PCE[0],
                            PCM[XLEN-1:IDXW+2], PCM[0]};

endmodule

// File: tb/tb_openhw_gshare_ncnt.sv
module tb_openhw_gshare_ncnt;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushD, FlushE, FlushM, FlushW;
  logic [31:0] PCNextF, PCF, PCD, PCE, PCM;
  logic        BPBranchF, BranchD, BranchE, BranchM, BranchW, PCSrcE;
  logic [2:0]  BPDirPredF;
  logic        BPDirPredWrongE, InitBusy;
`ifdef GSHARE_STATS_EN
  logic [31:0] BranchCountE, MispredCountE;
`endif

  openhw_gshare_ncnt #(.XLEN(32), .IDXW(4), .HISTW(10), .CTRW(3), .TYPE(1)) dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .PCNextF(PCNextF), .PCF(PCF), .PCD(PCD), .PCE(PCE), .PCM(PCM),
    .BPBranchF(BPBranchF), .BranchD(BranchD), .BranchE(BranchE), .BranchM(BranchM),
    .BranchW(BranchW), .PCSrcE(PCSrcE),
    .BPDirPredF(BPDirPredF), .BPDirPredWrongE(BPDirPredWrongE),
`ifdef GSHARE_STATS_EN
    .BranchCountE(BranchCountE), .MispredCountE(MispredCountE),
`endif
    .InitBusy(InitBusy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  tbl[16];
  logic [9:0]  ghr_mdl;
  int          n_br = 0;
  int          n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the index / counter arithmetic
  function automatic logic [3:0] m_fold(input logic [9:0] h);
    logic [11:0] e;
    e = {2'b00, h};
    return e[3:0] ^ e[7:4] ^ e[11:8];
  endfunction

  function automatic logic [3:0] m_hash(input logic [31:0] pc);
    return pc[5:2] ^ {pc[1], 3'b000};
  endfunction

  function automatic logic [2:0] m_sat(input logic [2:0] c, input logic t);
    if (t) return (c == 3'd7) ? 3'd7 : c + 3'd1;
    else   return (c == 3'd0) ? 3'd0 : c - 3'd1;
  endfunction

  function automatic logic [9:0] m_shift(input logic [9:0] g, input logic b);
    return {b, g[9:1]};
  endfunction

  // PC whose hash is exactly idx (pc[1] = 0).
  function automatic logic [31:0] pc_for(input logic [3:0] idx);
    return 32'h1000_0000 | {26'd0, idx, 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_sweep(input bit drive_m, output int n, output int bad);
    n = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!InitBusy) break;
      n++;
      if (BPDirPredF !== 3'd3) bad++;
      step();
      BranchM = drive_m && (n < 10);
      PCSrcE  = drive_m;
    end
  endtask

  // One isolated branch walked through F..W. In each of D/E/M/W another fetch
  // in F is aimed at the same PHT index to exercise that stage's forwarding.
  task automatic run_branch(input logic [31:0] pca, input logic t);
    logic [3:0] ia;
    logic [2:0] c, n;
    logic [9:0] gd, ge;
    ia = m_fold(ghr_mdl) ^ m_hash(pca);
    c  = tbl[ia];
    n  = m_sat(c, t);
    gd = m_shift(ghr_mdl, c[2]);
    ge = m_shift(ghr_mdl, t);
    // fetch request
    PCNextF = pca;
    exp_q.push_back({29'd0, c});
    step();
    // F: prediction from the table
    PCF = pca;
    PCNextF = pca ^ 32'h0000_0100;
    @(negedge clk);
    chk("predF", {29'd0, BPDirPredF}, exp_q.pop_front());
    step();
    // D
    BranchD = 1'b1;
    PCD = pca;
    PCF = pc_for(ia ^ m_fold(gd));
    exp_q.push_back({29'd0, {3{c[2]}}});
    @(negedge clk);
    chk("fwdD", {29'd0, BPDirPredF}, exp_q.pop_front());
    step();
    // E
    BranchD = 1'b0;
    BranchE = 1'b1;
    PCE = pca;
    PCSrcE = t;
    PCF = pc_for(ia ^ m_fold(ge));
    exp_q.push_back({29'd0, n});
    @(negedge clk);
    chk("fwdE", {29'd0, BPDirPredF}, exp_q.pop_front());
    chk("wrongE", {31'd0, BPDirPredWrongE}, {31'd0, t != c[2]});
    step();
    // M
    BranchE = 1'b0;
    BranchM = 1'b1;
    PCM = pca;
    PCSrcE = 1'b1;
    exp_q.push_back({29'd0, n});
    @(negedge clk);
    chk("fwdM", {29'd0, BPDirPredF}, exp_q.pop_front());
    chk("wrong_nobr", {31'd0, BPDirPredWrongE}, 32'd0);
    step();
    // W
    BranchM = 1'b0;
    BranchW = 1'b1;
    exp_q.push_back({29'd0, n});
    @(negedge clk);
    chk("fwdW", {29'd0, BPDirPredF}, exp_q.pop_front());
    step();
    BranchW = 1'b0;
    tbl[ia] = n;
    ghr_mdl = ge;
    n_br++;
    if (t != c[2]) n_mis++;
    $display("txn pc=%08h taken=%0d idx=%0d pred=%0d new=%0d", pca, t, ia, c, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, bad;
    logic [31:0] pcx;
    logic [9:0]  fold_pat;
    reset = 1'b1;
    {StallF, StallD, StallE, StallM, StallW} = '0;
    {FlushD, FlushE, FlushM, FlushW} = '0;
    {PCNextF, PCF, PCD, PCE, PCM} = '0;
    {BPBranchF, BranchD, BranchE, BranchM, BranchW, PCSrcE} = '0;
    repeat (3) step();
    chk("rst_busy", {31'd0, InitBusy}, 32'd1);
    chk("rst_pred", {29'd0, BPDirPredF}, 32'd3);
    chk("rst_wrong", {31'd0, BPDirPredWrongE}, 32'd0);
    reset = 1'b0;

    // full sweep
    count_sweep(1'b0, n, bad);
    chk("sweep_len", n, 32'd16);
    chk("sweep_pred", bad, 32'd0);
    step();

    // reset again, interrupt the sweep at cycle 7, then let it restart
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, InitBusy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_sweep(1'b1, n, bad);
    chk("resweep_len", n, 32'd16);
    chk("resweep_pred", bad, 32'd0);
    chk("ghr_hold", {22'd0, dut.ghr_m_q}, 32'd0);
    BranchM = 1'b0;
    step();

    for (int k = 0; k < 16; k++) tbl[k] = 3'd3;
    ghr_mdl = '0;

    // every entry reads back the init value
    for (int k = 0; k < 16; k++) begin
      PCNextF = pc_for(4'(k));
      exp_q.push_back(32'd3);
      step();
      PCF = pc_for(4'(k));
      @(negedge clk);
      chk("readback", {29'd0, BPDirPredF}, exp_q.pop_front());
    end
    step();

    // saturation at both ends on a single PC
    for (int i = 0; i < 5; i++)  run_branch(32'h0000_1230, 1'b0);
    for (int i = 0; i < 20; i++) run_branch(32'h0000_1230, 1'b1);

    // drive committed history to 10'b1011001110 (oldest bit first)
    fold_pat = 10'b1011001110;
    for (int i = 0; i < 10; i++) run_branch(32'h2000_0000 + 32'(i * 40), fold_pat[i]);
    pcx = 32'h0000_0ABE;
    PCNextF = pcx;
    @(negedge clk);
    chk("fold_ghr", {22'd0, dut.ghr_m_q}, 32'h0000_02CE);
    chk("fold_idx", {28'd0, dut.index_next_f}, {28'd0, m_hash(pcx)});
    step();

    // random branches
    for (int i = 0; i < 20; i++) begin
      pcx = $urandom;
      run_branch(pcx, 1'($urandom_range(0, 1)));
    end

`ifdef GSHARE_STATS_EN
    chk("stat_br", BranchCountE, n_br);
    chk("stat_mis", MispredCountE, n_mis);
`endif
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
